sadder_seq: RTL and testbench

//  Sequencer for the bit-serial adder. Latches two parallel N-bit operands and streams them
//  LSB-first as two serial bits per cycle, with shift enable and a carry-clear pulse.

---
 rtl/sadder_pkg.sv | 18 +
 rtl/shreg_n.sv | 24 ++
 rtl/sadder_seq.sv | 120 ++++++++++++
 tb/tb_sadder_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sadder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding and width limits.
package sadder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_MIN = 2;
    localparam int N_MAX = 32;

    function automatic bit n_in_range(input int n);
        return (n >= N_MIN) && (n <= N_MAX);
    endfunction

endpackage

// File: rtl/shreg_n.sv
// N-bit shift register: parallel load (priority) or shift right with serial-in at the MSB.
module shreg_n #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_dat,
    input  logic         shift,
    input  logic         sin,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_dat;
        end else if (shift) begin
            q <= {sin, q[N-1:1]};
        end
    end

endmodule

// File: rtl/sadder_seq.sv
// Sequencer around a bit-serial adder: loads two N-bit operands, streams them LSB-first,
// and gathers the serial sum plus final carry into a held parallel result.
module sadder_seq
    import sadder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ser_a,
    output logic         ser_b,
    output logic         ser_en,
    output logic         ser_clr,
    input  logic         ser_sum,
    input  logic         ser_cout
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!n_in_range(N)) begin : g_bad_n
        $error("sadder_seq: N must be within 2..32");
    end

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   sum_sr;
    logic           accept;
    logic           shifting;
    logic           unused_sum_lsb;

    assign accept   = (state == IDLE) && start;
    assign shifting = (state == SHIFT);

    shreg_n #(.N(N)) u_a_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_dat (a),
        .shift    (shifting),
        .sin      (1'b0),
        .q        (a_sr)
    );

    shreg_n #(.N(N)) u_b_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_dat (b),
        .shift    (shifting),
        .sin      (1'b0),
        .q        (b_sr)
    );

    // Sum collector: after N shifts it holds the full result, so it needs no load.
    shreg_n #(.N(N)) u_sum_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_dat ('0),
        .shift    (shifting),
        .sin      (ser_sum),
        .q        (sum_sr)
    );

    // The oldest collected bit falls off on the final shift and is never read.
    assign unused_sum_lsb = sum_sr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        state <= CLR;
                    end
                end
                CLR: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= {ser_sum, sum_sr[N-1:1]};
                        cout  <= ser_cout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready   = (state == IDLE);
    assign done    = (state == DONE);
    assign ser_en  = shifting;
    assign ser_clr = (state == CLR);
    assign ser_a   = shifting & a_sr[0];
    assign ser_b   = shifting & b_sr[0];

endmodule

// File: tb/tb_sadder_seq.sv
// Bench for sadder_seq at N=4 and N=8, each wrapped by a behavioural serial full adder.
module tb_sadder_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N=4 instance
    logic       start4, ready4, done4, cout4;
    logic [3:0] a4, b4, sum4;
    logic       sa4, sb4, sen4, sclr4, ssum4, scout4, carry4;

    // N=8 instance
    logic       start8, ready8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       sa8, sb8, sen8, sclr8, ssum8, scout8, carry8;

    sadder_seq #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .done(done4), .sum(sum4), .cout(cout4),
        .ser_a(sa4), .ser_b(sb4), .ser_en(sen4), .ser_clr(sclr4),
        .ser_sum(ssum4), .ser_cout(scout4)
    );

    sadder_seq #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .done(done8), .sum(sum8), .cout(cout8),
        .ser_a(sa8), .ser_b(sb8), .ser_en(sen8), .ser_clr(sclr8),
        .ser_sum(ssum8), .ser_cout(scout8)
    );

    // Behavioural serial full adders
    assign ssum4  = sa4 ^ sb4 ^ carry4;
    assign scout4 = (sa4 & sb4) | (carry4 & (sa4 ^ sb4));
    assign ssum8  = sa8 ^ sb8 ^ carry8;
    assign scout8 = (sa8 & sb8) | (carry8 & (sa8 ^ sb8));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry4 <= 1'b0;
            carry8 <= 1'b0;
        end else begin
            if (sclr4)     carry4 <= 1'b0;
            else if (sen4) carry4 <= scout4;
            if (sclr8)     carry8 <= 1'b0;
            else if (sen8) carry8 <= scout8;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One N=4 operation from IDLE; returns in IDLE. hold keeps start high with
    // fresh random operands on every cycle after the accept.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit hold,
                       output logic [3:0] s, output logic c, output int lat, output int hold_bad);
        logic [3:0] s_before;
        logic       c_before;
        bit         got;
        s_before = sum4;
        c_before = cout4;
        a4 = a; b4 = b; start4 = 1'b1;
        lat = 0; got = 0; hold_bad = 0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            start4 = hold;
            if (hold) begin
                a4 = 4'($urandom);
                b4 = 4'($urandom);
            end
            if (done4) got = 1;
            else if (sum4 !== s_before || cout4 !== c_before) hold_bad++;
        end
        start4 = 1'b0;
        s = sum4;
        c = cout4;
        tick();
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] s, output logic c, output int lat,
                       output int nclr, output int nen);
        bit got;
        a8 = a; b8 = b; start8 = 1'b1;
        lat = 0; got = 0; nclr = 0; nen = 0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            start8 = 1'b0;
            nclr += int'(sclr8);
            nen  += int'(sen8);
            if (done8) got = 1;
        end
        s = sum8;
        c = cout8;
        tick();
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic       c;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[6];
        logic [3:0] s;
        logic [7:0] s8;
        logic       c;
        logic [4:0] e;
        logic [8:0] e8;
        logic [3:0] qa[21];
        logic [3:0] qb[21];
        int         lat, hb, nclr, nen, ndone;

        vecs[0] = '{4'b1010, 4'b0011, 4'b1101, 1'b0};
        vecs[1] = '{4'b1111, 4'b0001, 4'b0000, 1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[3] = '{4'b0101, 4'b0101, 4'b1010, 1'b0};
        vecs[4] = '{4'b1001, 4'b1000, 4'b0001, 1'b1};
        vecs[5] = '{4'b0111, 4'b0110, 4'b1101, 1'b0};

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset4", {ready4, done4, cout4, sa4, sb4, sen4, sclr4, sum4}, {1'b1, 6'b0, 4'h0});
        chk("reset8", {ready8, done8, cout8, sa8, sb8, sen8, sclr8, sum8}, {1'b1, 6'b0, 8'h00});
        tick();

        // Directed table
        for (int i = 0; i < 6; i++) begin
            op4(vecs[i].a, vecs[i].b, 1'b0, s, c, lat, hb);
            chk($sformatf("vec%0d_sum", i), s, vecs[i].s);
            chk($sformatf("vec%0d_cout", i), c, vecs[i].c);
            chk($sformatf("vec%0d_lat", i), lat, 6);
            chk($sformatf("vec%0d_sum_hold", i), hb, 0);
        end

        // Random operands against plain addition
        for (int i = 0; i < 20; i++) begin
            logic [3:0] ra, rb;
            bit         rh;
            ra = 4'($urandom);
            rb = 4'($urandom);
            rh = 1'($urandom);
            e  = {1'b0, ra} + {1'b0, rb};
            op4(ra, rb, rh, s, c, lat, hb);
            chk($sformatf("rnd%0d_sum", i), s, e[3:0]);
            chk($sformatf("rnd%0d_cout", i), c, e[4]);
            chk($sformatf("rnd%0d_lat", i), lat, 6);
        end

        // start held high: one accept per N+3 cycles, operands taken at each accept
        for (int cyc = 0; cyc < 21; cyc++) begin
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            start4 = 1'b1;
            qa[cyc] = a4;
            qb[cyc] = b4;
            tick();
            chk($sformatf("hold_done_c%0d", cyc), done4, (cyc % 7) == 5);
            chk($sformatf("hold_ready_c%0d", cyc), ready4, (cyc % 7) == 6);
            if ((cyc % 7) == 5) begin
                e = {1'b0, qa[cyc-5]} + {1'b0, qb[cyc-5]};
                chk($sformatf("hold_sum_c%0d", cyc), {cout4, sum4}, e);
            end
        end
        start4 = 1'b0;

        // Reset during the second SHIFT cycle
        op4(4'b1010, 4'b0011, 1'b0, s, c, lat, hb);
        chk("pre_rst_sum", s, 4'b1101);
        a4 = 4'hC; b4 = 4'h3; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_state", {ready4, done4, sen4, sclr4, cout4, sum4}, {1'b1, 4'b0, 4'h0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ndone += int'(done4);
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_ready", ready4, 1'b1);
        chk("midrst_sum", {cout4, sum4}, 5'h00);
        op4(4'b0101, 4'b0101, 1'b0, s, c, lat, hb);
        chk("post_rst_sum", {c, s}, {1'b0, 4'b1010});
        chk("post_rst_lat", lat, 6);

        // start pulsed in CLR, SHIFT and DONE is ignored
        op4(4'b0110, 4'b0111, 1'b1, s, c, lat, hb);
        chk("ignore_sum", {c, s}, {1'b0, 4'b1101});
        chk("ignore_lat", lat, 6);
        chk("ignore_ready", ready4, 1'b1);
        tick();
        chk("ignore_no_queue", {ready4, done4}, 2'b10);

        // N=8 checks
        op8(8'hFF, 8'h01, s8, c, lat, nclr, nen);
        chk("n8_sum", s8, 8'h00);
        chk("n8_cout", c, 1'b1);
        chk("n8_lat", lat, 10);
        chk("n8_clr_cycles", nclr, 1);
        chk("n8_en_cycles", nen, 8);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            e8 = {1'b0, ra} + {1'b0, rb};
            op8(ra, rb, s8, c, lat, nclr, nen);
            chk($sformatf("n8_rnd%0d", i), {c, s8}, e8);
            chk($sformatf("n8_rnd%0d_lat", i), lat, 10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
